sram_fifo_prefetch: RTL and testbench
=====================================

SRAM_FIFO_PREFETCH -- requirements
Module: sram_fifo_prefetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width in bits.
REQ-002 SHALL have parameter RD_LATENCY, default 1, legal values 1 or 2: cycles from fifo_pop_o to valid fifo_data_i.
REQ-003 SHALL have parameter BUF_DEPTH, default RD_LATENCY+1: local skid-buffer entries, minimum RD_LATENCY+1.
REQ-004 clk_i  in  1  clock; one clock domain only.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 flush_i  in  1  synchronous discard of all buffered and in-flight data.
REQ-007 fifo_empty_i  in  1  upstream SRAM FIFO empty flag.
REQ-008 fifo_pop_o  out  1  read enable to upstream SRAM FIFO.
REQ-009 fifo_data_i  in  DATA_WIDTH  upstream read data, valid RD_LATENCY cycles after a pop.
REQ-010 valid_o  out  1  downstream data valid.
REQ-011 ready_i  in  1  downstream ready.
REQ-012 data_o  out  DATA_WIDTH  downstream data, head of skid buffer.
REQ-013 stall_cnt_o  out  16  cycles stalled by read latency (see Configuration).

Function
REQ-014 SHALL issue fifo_pop_o=1 in a cycle iff fifo_empty_i=0, flush_i=0, and inflight+occupancy < BUF_DEPTH, where inflight = pops issued whose data has not yet returned.
REQ-015 SHALL track returns with a RD_LATENCY-deep valid shift register; bit exiting the register writes fifo_data_i into the skid buffer that cycle.
REQ-016 skid buffer SHALL be a circular buffer with read/write pointers of $clog2(BUF_DEPTH) bits (minimum 1), wrapping at BUF_DEPTH-1 to 0 (non-power-of-2 depths included).
REQ-017 valid_o SHALL equal (occupancy != 0); data_o SHALL be the head entry, registered, no combinational path from fifo_data_i.
REQ-018 transfer SHALL occur when valid_o && ready_i; head pointer advances that cycle.
REQ-019 simultaneous return-write and downstream transfer SHALL leave occupancy unchanged and lose no data.
REQ-020 data SHALL leave in exactly upstream pop order.
REQ-021 latency SHALL be RD_LATENCY+1 cycles from fifo_pop_o to valid_o when the buffer is empty.
REQ-022 with ready_i held 1 and fifo_empty_i held 0, throughput SHALL be one word per cycle after the first word.
REQ-023 valid_o and data_o SHALL remain stable while valid_o && !ready_i.
REQ-024 flush_i SHALL, in the same cycle, clear occupancy, pointers, and the return shift register; the next cycle valid_o=0; data returning from pops issued before the flush SHALL be discarded.
REQ-025 inflight+occupancy SHALL never exceed BUF_DEPTH; overflow is impossible by construction.

Reset
REQ-026 on rst_ni=0: fifo_pop_o=0, valid_o=0, data_o=0, pointers=0, occupancy=0, return shift register=0, stall_cnt_o=0.
REQ-027 reset asserted mid-burst SHALL abandon all in-flight reads; no pop SHALL issue during reset or in the first cycle after release.

Configuration
REQ-028 macro SRAM_PREFETCH_STALL_CNT_EN defined: stall_cnt_o SHALL count cycles where valid_o=0, ready_i=1, and inflight!=0, saturating at 16'hFFFF, cleared by reset and flush_i.
REQ-029 macro undefined: stall_cnt_o SHALL be tied 0 and no counter logic synthesized; all other behaviour identical.

Structure
REQ-030 package sram_fifo_pkg SHALL hold the RD_LATENCY legal-range constants and the stall-counter width constant (16).
REQ-031 skid buffer SHALL be a sub-module sram_fifo_skid_buf (circular buffer with push/pop/occupancy); pop-issue and return tracking stay in the top.

Verification
REQ-032 RD_LATENCY=1, upstream holds 0x11,0x22,0x33, ready_i=1 -> pop at cycle 1, valid_o at cycle 3 with 0x11, then 0x22, 0x33 back-to-back.
REQ-033 RD_LATENCY=2, BUF_DEPTH=3, ready_i=0, 10 words upstream -> exactly 3 pops issued, valid_o=1, data_o stable at first word.
REQ-034 buffer full, ready_i pulsed 1 for one cycle -> one transfer, exactly one new pop, occupancy returns to 3, order preserved.
REQ-035 flush_i asserted the cycle after a pop with RD_LATENCY=2 -> valid_o=0 next cycle, returned word discarded, next delivered word is the next upstream entry.
REQ-036 rst_ni low for one cycle during a 5-word burst -> all outputs 0 during reset, no pop the first cycle after release.
REQ-037 SRAM_PREFETCH_STALL_CNT_EN defined, RD_LATENCY=2, single word, ready_i=1 -> stall_cnt_o=2 after delivery; macro undefined -> stall_cnt_o=0.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// Shared constants for the SRAM FIFO prefetch front-end: legal read latencies,
// stall-counter width and a pointer-width helper.
package sram_fifo_pkg;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;
  localparam int STALL_CNT_W    = 16;

  // Circular-buffer pointers never shrink below one bit, even for a depth of 1 or 2.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sram_fifo_skid_buf.sv
// Circular skid buffer with push/pop and occupancy. The head word is kept in its
// own register so data_o never sees a combinational path from push_data_i.
module sram_fifo_skid_buf
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  localparam int PTR_W     = ptr_width(DEPTH),
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [OCC_W-1:0]      occ_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occ;
  logic [DATA_WIDTH-1:0] head_q;
  logic                  do_pop;

  // Wrap explicitly so non-power-of-two depths behave.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop_i && (occ != '0);
  assign occ_o  = occ;
  assign head_o = head_q;

  // NOTE: storage has no reset; occupancy and the head register alone define
  // what is visible, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      head_q <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_i) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);

      case ({push_i, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase

      // Head follows the word that will sit at rd_ptr after this cycle.
      if (do_pop) begin
        if (occ > OCC_W'(1)) head_q <= mem[ptr_inc(rd_ptr)];
        else if (push_i)     head_q <= push_data_i;
      end else if (push_i && (occ == '0)) begin
        head_q <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/sram_fifo_prefetch.sv
// Prefetching read front-end for a fixed-latency SRAM FIFO feeding a valid/ready sink.
// Optional stall counter is built only when SRAM_PREFETCH_STALL_CNT_EN is defined.
module sram_fifo_prefetch
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   fifo_empty_i,
  output logic                   fifo_pop_o,
  input  logic [DATA_WIDTH-1:0]  fifo_data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int LVL_W = OCC_W + 1;

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("sram_fifo_prefetch: RD_LATENCY must be 1 or 2");
  end
  if (BUF_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
    $error("sram_fifo_prefetch: BUF_DEPTH must be at least RD_LATENCY+1");
  end

  logic                  rst_done;
  logic [RD_LATENCY-1:0] ret_sr;
  logic                  ret_exit;
  logic [OCC_W-1:0]      occ;
  logic [LVL_W-1:0]      inflight;
  logic [LVL_W-1:0]      level;
  logic                  xfer;

  assign ret_exit = ret_sr[RD_LATENCY-1];
  assign valid_o  = (occ != '0);
  assign xfer     = valid_o && ready_i;

  // NOTE: combinational blocks use blocking assignments and give every target a
  // default first, so no latch is inferred.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + LVL_W'(ret_sr[i]);
    end
  end

  // The word leaving downstream this cycle frees its slot now, which keeps a
  // continuous stream at one pop per cycle without ever overcommitting the buffer.
  assign level      = inflight + LVL_W'(occ) - LVL_W'(xfer);
  assign fifo_pop_o = rst_done && !flush_i && !fifo_empty_i && (level < LVL_W'(BUF_DEPTH));

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_done <= 1'b0;
      ret_sr   <= '0;
    end else begin
      rst_done <= 1'b1;
      if (flush_i) ret_sr <= '0;
      else         ret_sr <= (ret_sr << 1) | RD_LATENCY'(fifo_pop_o);
    end
  end

  sram_fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_skid_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (ret_exit),
    .push_data_i (fifo_data_i),
    .pop_i       (xfer),
    .occ_o       (occ),
    .head_o      (data_o)
  );

`ifdef SRAM_PREFETCH_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (flush_i) begin
      stall_cnt <= '0;
    end else if (!valid_o && ready_i && (inflight != '0) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sram_fifo_prefetch.sv
// Directed bench: one instance at RD_LATENCY=1 (depth 2), one at RD_LATENCY=2 (depth 3),
// each fed by a small upstream SRAM FIFO model.
module tb_sram_fifo_prefetch;

  localparam int DW = 32;

`ifdef SRAM_PREFETCH_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic          flush1 = 1'b0, ready1 = 1'b0, pop1, valid1, empty1;
  logic [DW-1:0] data1, fdata1;
  logic [15:0]   stall1;
  logic          flush2 = 1'b0, ready2 = 1'b0, pop2, valid2, empty2;
  logic [DW-1:0] data2, fdata2;
  logic [15:0]   stall2;

  sram_fifo_prefetch #(.DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1), .fifo_empty_i(empty1),
    .fifo_pop_o(pop1), .fifo_data_i(fdata1), .valid_o(valid1), .ready_i(ready1),
    .data_o(data1), .stall_cnt_o(stall1)
  );

  sram_fifo_prefetch #(.DATA_WIDTH(DW), .RD_LATENCY(2), .BUF_DEPTH(3)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush2), .fifo_empty_i(empty2),
    .fifo_pop_o(pop2), .fifo_data_i(fdata2), .valid_o(valid2), .ready_i(ready2),
    .data_o(data2), .stall_cnt_o(stall2)
  );

  // Upstream models: words leave on a sampled pop and appear RD_LATENCY cycles later.
  logic [DW-1:0] up_mem1 [16];
  int            up_n1 = 0, up_idx1 = 0, pops1 = 0;
  logic          up_clr1 = 1'b0;
  logic [DW-1:0] pipe1a = '0;
  assign empty1 = (up_idx1 >= up_n1);
  assign fdata1 = pipe1a;

  always @(posedge clk) begin
    pipe1a <= pop1 ? up_mem1[up_idx1[3:0]] : 32'hDEAD_BEEF;
    if (up_clr1) begin
      up_idx1 <= 0;
      pops1   <= 0;
    end else if (pop1) begin
      up_idx1 <= up_idx1 + 1;
      pops1   <= pops1 + 1;
    end
  end

  logic [DW-1:0] up_mem2 [16];
  int            up_n2 = 0, up_idx2 = 0, pops2 = 0;
  logic          up_clr2 = 1'b0;
  logic [DW-1:0] pipe2a = '0, pipe2b = '0;
  assign empty2 = (up_idx2 >= up_n2);
  assign fdata2 = pipe2b;

  always @(posedge clk) begin
    pipe2a <= pop2 ? up_mem2[up_idx2[3:0]] : 32'hDEAD_BEEF;
    pipe2b <= pipe2a;
    if (up_clr2) begin
      up_idx2 <= 0;
      pops2   <= 0;
    end else if (pop2) begin
      up_idx2 <= up_idx2 + 1;
      pops2   <= pops2 + 1;
    end
  end

  task automatic clear_up1();
    @(negedge clk); up_n1 = 0; up_clr1 = 1'b1;
    @(negedge clk); up_clr1 = 1'b0;
  endtask

  task automatic clear_up2();
    @(negedge clk); up_n2 = 0; up_clr2 = 1'b1;
    @(negedge clk); up_clr2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready1 = 1'b1; ready2 = 1'b1; up_n1 = 4; up_n2 = 4;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (pop1 !== 1'b0)    begin tests_failed++; $display("FAIL reset_pop1: got %0b want 0", pop1); end
    tests_run++; if (valid1 !== 1'b0)  begin tests_failed++; $display("FAIL reset_valid1: got %0b want 0", valid1); end
    tests_run++; if (data1 !== '0)     begin tests_failed++; $display("FAIL reset_data1: got %h want 0", data1); end
    tests_run++; if (stall1 !== 16'd0) begin tests_failed++; $display("FAIL reset_stall1: got %0d want 0", stall1); end
    tests_run++; if (pop2 !== 1'b0)    begin tests_failed++; $display("FAIL reset_pop2: got %0b want 0", pop2); end
    tests_run++; if (valid2 !== 1'b0)  begin tests_failed++; $display("FAIL reset_valid2: got %0b want 0", valid2); end
    tests_run++; if (data2 !== '0)     begin tests_failed++; $display("FAIL reset_data2: got %h want 0", data2); end
    up_n1 = 0; up_n2 = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Three words at RD_LATENCY=1: pop in cycle 1, data in cycles 3..5.
  task automatic test_basic();
    bit            exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] exp_d [6] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
    ready1 = 1'b1;
    clear_up1();
    up_mem1[0] = 32'h11; up_mem1[1] = 32'h22; up_mem1[2] = 32'h33; up_n1 = 3;
    #1;
    tests_run++; if (pop1 !== 1'b1) begin tests_failed++; $display("FAIL basic_first_pop: got %0b want 1", pop1); end
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      tests_run++;
      if (valid1 !== exp_v[c]) begin tests_failed++; $display("FAIL basic_valid_c%0d: got %0b want %0b", c + 1, valid1, exp_v[c]); end
      if (exp_v[c]) begin
        tests_run++;
        if (data1 !== exp_d[c]) begin tests_failed++; $display("FAIL basic_data_c%0d: got %h want %h", c + 1, data1, exp_d[c]); end
      end
    end
  endtask

  // RD_LATENCY=2, depth 3, sink stalled: exactly three pops, head held.
  task automatic test_fill();
    ready2 = 1'b0;
    clear_up2();
    for (int i = 0; i < 10; i++) up_mem2[i] = 32'hA0 + i;
    up_n2 = 10;
    repeat (8) @(negedge clk);
    #1;
    tests_run++; if (pops2 !== 3)      begin tests_failed++; $display("FAIL fill_pops: got %0d want 3", pops2); end
    tests_run++; if (valid2 !== 1'b1)  begin tests_failed++; $display("FAIL fill_valid: got %0b want 1", valid2); end
    for (int c = 0; c < 3; c++) begin
      tests_run++; if (data2 !== 32'hA0) begin tests_failed++; $display("FAIL fill_hold_data: got %h want a0", data2); end
      tests_run++; if (pop2 !== 1'b0)    begin tests_failed++; $display("FAIL fill_hold_pop: got %0b want 0", pop2); end
      @(negedge clk); #1;
    end
  endtask

  // Single-cycle ready pulse on a full buffer.
  task automatic test_one_xfer();
    ready2 = 1'b1; #1;
    tests_run++; if (pop2 !== 1'b1)    begin tests_failed++; $display("FAIL xfer_pop: got %0b want 1", pop2); end
    tests_run++; if (data2 !== 32'hA0) begin tests_failed++; $display("FAIL xfer_data: got %h want a0", data2); end
    @(negedge clk); ready2 = 1'b0; #1;
    tests_run++; if (data2 !== 32'hA1) begin tests_failed++; $display("FAIL xfer_next_head: got %h want a1", data2); end
    repeat (4) @(negedge clk);
    #1;
    tests_run++; if (pops2 !== 4)      begin tests_failed++; $display("FAIL xfer_pops: got %0d want 4", pops2); end
    tests_run++; if (pop2 !== 1'b0)    begin tests_failed++; $display("FAIL xfer_refull_pop: got %0b want 0", pop2); end
    tests_run++; if (data2 !== 32'hA1) begin tests_failed++; $display("FAIL xfer_hold: got %h want a1", data2); end
  endtask

  // Drain A1..A9 with ready held: one word every cycle, in order.
  task automatic test_back_to_back();
    @(negedge clk); ready2 = 1'b1; #1;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) begin @(negedge clk); #1; end
      tests_run++; if (valid2 !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid_%0d: got %0b want 1", i, valid2); end
      tests_run++; if (data2 !== 32'hA0 + i) begin tests_failed++; $display("FAIL b2b_data_%0d: got %h want %h", i, data2, 32'hA0 + i); end
    end
    @(negedge clk); #1;
    tests_run++; if (valid2 !== 1'b0) begin tests_failed++; $display("FAIL b2b_empty: got %0b want 0", valid2); end
  endtask

  // Flush the cycle after a pop at RD_LATENCY=2; B0 must vanish, B1 comes next.
  task automatic test_flush();
    logic [DW-1:0] exp_b [3] = '{32'hB1, 32'hB2, 32'hB3};
    ready2 = 1'b1;
    clear_up2();
    for (int i = 0; i < 4; i++) up_mem2[i] = 32'hB0 + i;
    up_n2 = 4; #1;
    tests_run++; if (pop2 !== 1'b1)   begin tests_failed++; $display("FAIL flush_pre_pop: got %0b want 1", pop2); end
    @(negedge clk); flush2 = 1'b1; #1;
    tests_run++; if (pop2 !== 1'b0)   begin tests_failed++; $display("FAIL flush_pop_blocked: got %0b want 0", pop2); end
    @(negedge clk); flush2 = 1'b0; #1;
    tests_run++; if (valid2 !== 1'b0) begin tests_failed++; $display("FAIL flush_valid_next: got %0b want 0", valid2); end
    @(negedge clk); #1;
    tests_run++; if (valid2 !== 1'b0) begin tests_failed++; $display("FAIL flush_discard: got %0b want 0", valid2); end
    @(negedge clk); @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      tests_run++; if (valid2 !== 1'b1) begin tests_failed++; $display("FAIL flush_after_valid_%0d: got %0b want 1", i, valid2); end
      tests_run++; if (data2 !== exp_b[i]) begin tests_failed++; $display("FAIL flush_after_data_%0d: got %h want %h", i, data2, exp_b[i]); end
    end
  endtask

  // One-cycle reset in the middle of a five-word burst on the latency-1 instance.
  task automatic test_reset_mid_burst();
    int wait_cnt;
    ready1 = 1'b1;
    clear_up1();
    for (int i = 0; i < 5; i++) up_mem1[i] = 32'hC0 + i;
    up_n1 = 5;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0; #1;
    tests_run++; if (pop1 !== 1'b0)    begin tests_failed++; $display("FAIL rstmid_pop: got %0b want 0", pop1); end
    tests_run++; if (valid1 !== 1'b0)  begin tests_failed++; $display("FAIL rstmid_valid: got %0b want 0", valid1); end
    tests_run++; if (data1 !== '0)     begin tests_failed++; $display("FAIL rstmid_data: got %h want 0", data1); end
    tests_run++; if (stall1 !== 16'd0) begin tests_failed++; $display("FAIL rstmid_stall: got %0d want 0", stall1); end
    tests_run++; if (data2 !== '0)     begin tests_failed++; $display("FAIL rstmid_data2: got %h want 0", data2); end
    @(negedge clk); rst_n = 1'b1; #1;
    tests_run++; if (pop1 !== 1'b0)    begin tests_failed++; $display("FAIL rstmid_release_pop: got %0b want 0", pop1); end
    tests_run++; if (pops1 !== 2)      begin tests_failed++; $display("FAIL rstmid_pops: got %0d want 2", pops1); end
    @(negedge clk); #1;
    tests_run++; if (pop1 !== 1'b1)    begin tests_failed++; $display("FAIL rstmid_resume_pop: got %0b want 1", pop1); end
    wait_cnt = 0;
    while (valid1 !== 1'b1 && wait_cnt < 10) begin
      @(negedge clk); #1; wait_cnt++;
    end
    tests_run++; if (valid1 !== 1'b1)  begin tests_failed++; $display("FAIL rstmid_timeout: got valid %0b want 1", valid1); end
    tests_run++; if (data1 !== 32'hC2) begin tests_failed++; $display("FAIL rstmid_first_word: got %h want c2", data1); end
    tests_run++;
    if (stall1 !== (STALL_EN ? 16'd1 : 16'd0)) begin
      tests_failed++; $display("FAIL rstmid_stall_cnt: got %0d want %0d", stall1, STALL_EN ? 1 : 0);
    end
    repeat (4) @(negedge clk);
  endtask

  // Single word at RD_LATENCY=2 with ready held: two stalled cycles.
  task automatic test_stall_cnt();
    int wait_cnt;
    ready2 = 1'b1;
    clear_up2();
    up_mem2[0] = 32'hD0; up_n2 = 1; #1;
    wait_cnt = 0;
    while (valid2 !== 1'b1 && wait_cnt < 10) begin
      @(negedge clk); #1; wait_cnt++;
    end
    tests_run++; if (wait_cnt !== 3)   begin tests_failed++; $display("FAIL stall_latency: got %0d want 3", wait_cnt); end
    tests_run++; if (data2 !== 32'hD0) begin tests_failed++; $display("FAIL stall_data: got %h want d0", data2); end
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (stall2 !== (STALL_EN ? 16'd2 : 16'd0)) begin
      tests_failed++; $display("FAIL stall_cnt: got %0d want %0d", stall2, STALL_EN ? 2 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_one_xfer();
    test_back_to_back();
    test_flush();
    test_reset_mid_burst();
    test_stall_cnt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
